instruction_queue: RTL and testbench
====================================

Name: instruction_queue

Overview:
- FIFO between fetch and decode/dispatch; buffers {PC, instruction word} pairs returned by the I-cache.
- Fetch pushes an entry on each accepted I-cache response; decode pops entries with a valid/ready handshake.
- Backpressures fetch through iq_really_full.
- Emptied in one cycle on flush (branch mispredict, halt).

Parameters:
- DEPTH, 8, number of entries; must be a power of 2 and at least 2.
- PTR_W, $clog2(DEPTH), width of the head/tail pointers.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-low; rst==0 at a rising clk edge resets.
- load_iq_fetch  input  1  enqueue strobe from fetch.
- pc_in  input  32  PC of the instruction being enqueued.
- instr_in  input  32  instruction word (I-cache read data).
- flush_iq_fetch  input  1  discard all entries.
- iq_really_full  output  1  count == DEPTH; fetch must not load.
- iq_valid  output  1  head entry is valid (count != 0).
- pc_out  output  32  PC of head entry.
- instr_out  output  32  instruction of head entry.
- dispatch_ready  input  1  decode accepts the head entry this cycle.
- iq_count  output  PTR_W+1  number of valid entries.
- iq_overflow  output  1  sticky error: load attempted while full.

Behaviour:
- Storage: DEPTH x 64-bit array; head and tail pointers PTR_W bits; count PTR_W+1 bits.
- Pointers wrap modulo DEPTH naturally (DEPTH-1 -> 0).
- Reset (rst==0 at edge): head=0, tail=0, count=0, iq_overflow=0.
- Array contents are not reset.
- Outputs in reset: iq_valid=0, iq_really_full=0, iq_count=0.
- pc_out/instr_out are don't-care whenever iq_valid=0.
- Output is first-word-fall-through:
  - pc_out/instr_out are read combinationally from array[head].
  - A pushed entry is visible at the head the cycle after the load edge (1-cycle latency).
  - No same-cycle bypass from input to output.
- Derived flags, combinational from count: iq_valid = (count!=0); iq_really_full = (count==DEPTH).
- push = load_iq_fetch && (!iq_really_full || pop).
- pop = iq_valid && dispatch_ready.
- Priority per edge: reset > flush > push/pop.
- Flush (flush_iq_fetch=1): head=tail=count=0 next cycle.
  - Any simultaneous load or pop is discarded; the array write is ignored.
  - iq_overflow is not cleared by flush.
- Push only: array[tail]<=({pc_in,instr_in}), tail+1, count+1.
- Pop only: head+1, count-1.
- Push and pop in the same cycle: both pointers advance, count unchanged.
  - Legal when full: a freed slot is reused in the same cycle.
  - Legal when count==1: the new entry becomes the head next cycle.
- load while full with no pop: entry dropped, state unchanged, iq_overflow<=1 (sticky until reset).
- dispatch_ready while empty: no effect; count never underflows.
- Reset mid-operation overrides any concurrent load/flush/pop.

Test Plan:
- Reset then fill: hold rst=0 for 2 cycles, release, then load 8 entries with pc 0x60,0x64..0x7C and instr 0x13+i, dispatch_ready=0 -> iq_count=8, iq_really_full=1, iq_valid=1, pc_out=0x60.
- Drain in order from the full queue: dispatch_ready=1 for 8 cycles -> pc_out sequence 0x60..0x7C, instr 0x13..0x1A; then iq_valid=0, iq_count=0.
- Wrap-around: push 5, pop 5, then push 6 (pc 0x100..0x114) -> tail wraps past 7, pops return 0x100..0x114 in order, count correct at every step.
- Simultaneous push/pop:
  - At full, load pc 0x200 with dispatch_ready=1 -> count stays 8, no overflow, 0x200 popped last.
  - At count=1, same stimulus -> pc_out=0x200 next cycle.
- Flush priority: count=4, assert flush_iq_fetch with load_iq_fetch=1 and dispatch_ready=1 -> next cycle count=0, iq_valid=0, iq_really_full=0; then load pc 0x300 -> pc_out=0x300 one cycle later.
- Overflow and reset: when full, load with dispatch_ready=0 -> count=8, iq_overflow=1, head unchanged.
  - Subsequent flush leaves iq_overflow=1.
  - rst=0 for one edge clears iq_overflow and count.

Source files
------------

// File: rtl/instruction_queue_if.sv
// Fetch/decode-facing signal bundle for the instruction queue.
// master = fetch + decode side, slave = the queue itself.
interface instruction_queue_if #(
    parameter int DEPTH = 8
) ();
    localparam int PTR_W = $clog2(DEPTH);

    logic             load_iq_fetch;
    logic [31:0]      pc_in;
    logic [31:0]      instr_in;
    logic             flush_iq_fetch;
    logic             dispatch_ready;
    logic             iq_really_full;
    logic             iq_valid;
    logic [31:0]      pc_out;
    logic [31:0]      instr_out;
    logic [PTR_W:0]   iq_count;
    logic             iq_overflow;

    modport master (
        output load_iq_fetch, pc_in, instr_in, flush_iq_fetch, dispatch_ready,
        input  iq_really_full, iq_valid, pc_out, instr_out, iq_count, iq_overflow
    );

    modport slave (
        input  load_iq_fetch, pc_in, instr_in, flush_iq_fetch, dispatch_ready,
        output iq_really_full, iq_valid, pc_out, instr_out, iq_count, iq_overflow
    );
endinterface

// File: rtl/instruction_queue.sv
// First-word-fall-through FIFO of {PC, instruction} pairs between fetch and decode.
// Single-cycle flush; sticky overflow flag when fetch loads into a full queue.
module instruction_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input logic               clk,
    input logic               rst,
    instruction_queue_if.slave iq
);
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } iq_entry_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    iq_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic             overflow;

    logic valid;
    logic full;
    logic push;
    logic pop;

    assign valid = (count != '0);
    assign full  = (count == FULL_CNT);
    assign pop   = valid && iq.dispatch_ready;
    // A pop frees the slot the same edge, so a full queue may still accept a load.
    assign push  = iq.load_iq_fetch && (!full || pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (iq.flush_iq_fetch) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
            if (iq.load_iq_fetch && full && !pop) overflow <= 1'b1;
        end
    end

    // Storage carries no reset; head/count gate what is observable.
    always_ff @(posedge clk) begin
        if (rst && !iq.flush_iq_fetch && push)
            mem[tail] <= '{pc: iq.pc_in, instr: iq.instr_in};
    end

    assign iq.iq_valid       = valid;
    assign iq.iq_really_full = full;
    assign iq.iq_count       = count;
    assign iq.iq_overflow    = overflow;
    assign iq.pc_out         = mem[head].pc;
    assign iq.instr_out      = mem[head].instr;
endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue: fill/drain, wrap, simultaneous push/pop,
// flush priority, overflow stickiness and reset.
module tb_instruction_queue;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    instruction_queue_if #(.DEPTH(8)) iq ();
    instruction_queue #(.DEPTH(8)) dut (.clk(clk), .rst(rst), .iq(iq));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iq.load_iq_fetch  = 1'b0;
        iq.flush_iq_fetch = 1'b0;
        iq.dispatch_ready = 1'b0;
    endtask

    task automatic push1(input logic [31:0] pc, input logic [31:0] ins);
        iq.load_iq_fetch = 1'b1;
        iq.pc_in = pc;
        iq.instr_in = ins;
        tick();
        iq.load_iq_fetch = 1'b0;
    endtask

    task automatic pop1();
        iq.dispatch_ready = 1'b1;
        tick();
        iq.dispatch_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        iq.pc_in = '0;
        iq.instr_in = '0;
        rst = 1'b0;
        tick();
        tick();
        vectors++;
        if (iq.iq_count !== 4'd0 || iq.iq_valid !== 1'b0 || iq.iq_really_full !== 1'b0 ||
            iq.iq_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state got cnt=%0d v=%b f=%b ovf=%b exp 0 0 0 0",
                     iq.iq_count, iq.iq_valid, iq.iq_really_full, iq.iq_overflow);
        end
        rst = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            push1(32'h60 + 32'(4*i), 32'h13 + 32'(i));
            vectors++;
            if (iq.iq_count !== 4'(i+1)) begin
                miscompares++;
                $display("FAIL fill_count[%0d] got %0d exp %0d", i, iq.iq_count, i+1);
            end
        end
        vectors++;
        if (iq.iq_really_full !== 1'b1 || iq.iq_valid !== 1'b1 || iq.pc_out !== 32'h60 ||
            iq.instr_out !== 32'h13) begin
            miscompares++;
            $display("FAIL fill_flags got f=%b v=%b pc=%h ins=%h exp 1 1 60 13",
                     iq.iq_really_full, iq.iq_valid, iq.pc_out, iq.instr_out);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (iq.pc_out !== 32'h60 + 32'(4*i) || iq.instr_out !== 32'h13 + 32'(i)) begin
                miscompares++;
                $display("FAIL drain_head[%0d] got pc=%h ins=%h exp pc=%h ins=%h", i,
                         iq.pc_out, iq.instr_out, 32'h60 + 32'(4*i), 32'h13 + 32'(i));
            end
            pop1();
        end
        vectors++;
        if (iq.iq_valid !== 1'b0 || iq.iq_count !== 4'd0) begin
            miscompares++;
            $display("FAIL drain_empty got v=%b cnt=%0d exp 0 0", iq.iq_valid, iq.iq_count);
        end
        pop1();
        vectors++;
        if (iq.iq_count !== 4'd0 || iq.iq_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL pop_empty got cnt=%0d v=%b exp 0 0", iq.iq_count, iq.iq_valid);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 5; i++) push1(32'h80 + 32'(4*i), 32'(i));
        for (int i = 0; i < 5; i++) pop1();
        for (int i = 0; i < 6; i++) begin
            push1(32'h100 + 32'(4*i), 32'hA0 + 32'(i));
            vectors++;
            if (iq.iq_count !== 4'(i+1)) begin
                miscompares++;
                $display("FAIL wrap_push_count[%0d] got %0d exp %0d", i, iq.iq_count, i+1);
            end
        end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (iq.pc_out !== 32'h100 + 32'(4*i) || iq.instr_out !== 32'hA0 + 32'(i)) begin
                miscompares++;
                $display("FAIL wrap_head[%0d] got pc=%h exp %h", i, iq.pc_out, 32'h100 + 32'(4*i));
            end
            pop1();
            vectors++;
            if (iq.iq_count !== 4'(5-i)) begin
                miscompares++;
                $display("FAIL wrap_pop_count[%0d] got %0d exp %0d", i, iq.iq_count, 5-i);
            end
        end
    endtask

    task automatic test_simul_full();
        for (int i = 0; i < 8; i++) push1(32'h180 + 32'(4*i), 32'(i));
        iq.dispatch_ready = 1'b1;
        push1(32'h200, 32'hBEEF);
        iq.dispatch_ready = 1'b0;
        vectors++;
        if (iq.iq_count !== 4'd8 || iq.iq_overflow !== 1'b0 || iq.pc_out !== 32'h184) begin
            miscompares++;
            $display("FAIL simul_full got cnt=%0d ovf=%b pc=%h exp 8 0 184",
                     iq.iq_count, iq.iq_overflow, iq.pc_out);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (iq.pc_out !== ((i == 7) ? 32'h200 : 32'h184 + 32'(4*i))) begin
                miscompares++;
                $display("FAIL simul_full_order[%0d] got pc=%h exp %h", i, iq.pc_out,
                         (i == 7) ? 32'h200 : 32'h184 + 32'(4*i));
            end
            pop1();
        end
    endtask

    task automatic test_simul_one();
        push1(32'h1F0, 32'h1);
        iq.dispatch_ready = 1'b1;
        push1(32'h200, 32'h2);
        iq.dispatch_ready = 1'b0;
        vectors++;
        if (iq.iq_count !== 4'd1 || iq.pc_out !== 32'h200 || iq.instr_out !== 32'h2) begin
            miscompares++;
            $display("FAIL simul_one got cnt=%0d pc=%h ins=%h exp 1 200 2",
                     iq.iq_count, iq.pc_out, iq.instr_out);
        end
        pop1();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) push1(32'h280 + 32'(4*i), 32'(i));
        iq.flush_iq_fetch = 1'b1;
        iq.dispatch_ready = 1'b1;
        push1(32'h2F0, 32'h9);
        idle();
        vectors++;
        if (iq.iq_count !== 4'd0 || iq.iq_valid !== 1'b0 || iq.iq_really_full !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_clear got cnt=%0d v=%b f=%b exp 0 0 0",
                     iq.iq_count, iq.iq_valid, iq.iq_really_full);
        end
        // load presented but not yet clocked: must not show at the head
        iq.load_iq_fetch = 1'b1;
        iq.pc_in = 32'h300;
        iq.instr_in = 32'h33;
        #1;
        vectors++;
        if (iq.iq_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL no_bypass got v=%b exp 0", iq.iq_valid);
        end
        tick();
        iq.load_iq_fetch = 1'b0;
        vectors++;
        if (iq.iq_valid !== 1'b1 || iq.pc_out !== 32'h300 || iq.iq_count !== 4'd1) begin
            miscompares++;
            $display("FAIL flush_reload got v=%b pc=%h cnt=%0d exp 1 300 1",
                     iq.iq_valid, iq.pc_out, iq.iq_count);
        end
        pop1();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) push1(32'h400 + 32'(4*i), 32'(i));
        push1(32'h500, 32'h55);
        vectors++;
        if (iq.iq_count !== 4'd8 || iq.iq_overflow !== 1'b1 || iq.pc_out !== 32'h400) begin
            miscompares++;
            $display("FAIL overflow got cnt=%0d ovf=%b pc=%h exp 8 1 400",
                     iq.iq_count, iq.iq_overflow, iq.pc_out);
        end
        iq.flush_iq_fetch = 1'b1;
        tick();
        iq.flush_iq_fetch = 1'b0;
        vectors++;
        if (iq.iq_overflow !== 1'b1 || iq.iq_count !== 4'd0) begin
            miscompares++;
            $display("FAIL ovf_after_flush got ovf=%b cnt=%0d exp 1 0", iq.iq_overflow, iq.iq_count);
        end
        push1(32'h600, 32'h66);
        // reset must win over a concurrent load and pop
        rst = 1'b0;
        iq.dispatch_ready = 1'b1;
        push1(32'h700, 32'h77);
        idle();
        rst = 1'b1;
        vectors++;
        if (iq.iq_overflow !== 1'b0 || iq.iq_count !== 4'd0 || iq.iq_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_clear got ovf=%b cnt=%0d v=%b exp 0 0 0",
                     iq.iq_overflow, iq.iq_count, iq.iq_valid);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simul_full();
        test_simul_one();
        test_flush();
        test_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
